// File: rtl/simd_mul_pkg.sv
// simd_mul_pkg
//   Shared types and helpers for the SIMD multiply packing scheduler:
//   precision-mode encodings, FSM state encodings and a lanes-per-mode helper.
package simd_mul_pkg;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'b00,
        MODE_INT4 = 2'b01,
        MODE_INT2 = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FILL  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_OUT   = 2'b11
    } state_t;

    // Number of lanes packed into one 8-bit operand pair for a given mode.
    // The reserved mode reports a single lane; it is never packed.
    function automatic logic [2:0] lanes_per_mode(input mode_t mode);
        case (mode)
            MODE_INT4: lanes_per_mode = 3'd2;
            MODE_INT2: lanes_per_mode = 3'd4;
            default:   lanes_per_mode = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/simd_mul_scheduler_mult.sv
// eight_bit_multiplier
//   Combinational SIMD multiplier over one 8-bit operand pair. All three
//   lane interpretations are produced in parallel; the caller selects one.
//   Ports:
//     a, b  in  8   packed unsigned operands
//     p8    out 16  full 8x8 product
//     p4    out 16  {a[7:4]*b[7:4], a[3:0]*b[3:0]}, 8 bits per lane
//     p2    out 16  four 2x2 products, 4 bits per lane, lane 0 in [3:0]
module eight_bit_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p8,
    output logic [15:0] p4,
    output logic [15:0] p2
);

    assign p8 = {8'b0, a} * {8'b0, b};

    always_comb begin
        p4 = '0;
        for (int k = 0; k < 2; k++) begin
            p4[k*8 +: 8] = {4'b0, a[k*4 +: 4]} * {4'b0, b[k*4 +: 4]};
        end
    end

    always_comb begin
        p2 = '0;
        for (int k = 0; k < 4; k++) begin
            p2[k*4 +: 4] = {2'b0, a[k*2 +: 2]} * {2'b0, b[k*2 +: 2]};
        end
    end

endmodule

// File: rtl/simd_mul_scheduler.sv
// simd_mul_scheduler
//   Packs same-mode single-lane multiply requests into one 8-bit operand
//   pair, issues the pair to an eight_bit_multiplier and returns the packed
//   products with a lane-valid mask. Partial packs issue on flush, on a mode
//   change, or after TIMEOUT idle cycles in FILL (TIMEOUT = 0 disables it).
//   Ports:
//     CLK, nrst             clock (rising edge), synchronous active-low reset
//     in_valid/in_ready     request handshake
//     in_mode               00 int8, 01 int4, 10 int2, 11 reserved
//     in_a, in_b            right-aligned unsigned lane operands
//     flush                 force issue of the current partial pack
//     out_valid/out_ready   result handshake
//     out_mode, out_lanes   mode and lane-valid mask of the issued pack
//     out_data              packed products
//     err                   one-cycle pulse when a reserved-mode request is consumed
module simd_mul_scheduler
    import simd_mul_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_mode,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_mode,
    output logic [3:0]  out_lanes,
    output logic [15:0] out_data,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_t           state;
    mode_t            pack_mode;
    logic [7:0]       pa, pb;
    logic [3:0]       mask;
    logic [1:0]       lane_idx;
    logic [CNT_W-1:0] cnt;

    mode_t      req_mode;
    logic [7:0] pa_ins, pb_ins;
    logic [3:0] mask_ins;
    logic       full_ins;
    logic       mismatch;
    logic       timeout_hit;
    logic [15:0] p8, p4, p2;
    logic [15:0] prod_sel;

    assign req_mode = mode_t'(in_mode);

    // A request of another mode (reserved included) closes the partial pack.
    assign mismatch = in_valid && (req_mode != pack_mode);

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        case (state)
            ST_EMPTY: in_ready = 1'b1;
            ST_FILL:  in_ready = !mismatch;
            default:  in_ready = 1'b0;
        endcase
    end

    // Pack registers with the incoming request merged into lane lane_idx.
    // Only meaningful when the request is accepted; lane_idx is 0 in EMPTY.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        pa_ins   = pa;
        pb_ins   = pb;
        mask_ins = mask | (4'b0001 << lane_idx);
        case (req_mode)
            MODE_INT4: begin
                pa_ins = pa | ({4'b0, in_a[3:0]} << {lane_idx[0], 2'b00});
                pb_ins = pb | ({4'b0, in_b[3:0]} << {lane_idx[0], 2'b00});
            end
            MODE_INT2: begin
                pa_ins = pa | ({6'b0, in_a[1:0]} << {lane_idx, 1'b0});
                pb_ins = pb | ({6'b0, in_b[1:0]} << {lane_idx, 1'b0});
            end
            default: begin
                pa_ins = in_a;
                pb_ins = in_b;
            end
        endcase
        full_ins = ({1'b0, lane_idx} == (lanes_per_mode(req_mode) - 3'd1));
    end

    eight_bit_multiplier u_mult (
        .a  (pa),
        .b  (pb),
        .p8 (p8),
        .p4 (p4),
        .p2 (p2)
    );

    always_comb begin
        case (pack_mode)
            MODE_INT8: prod_sel = p8;
            MODE_INT4: prod_sel = p4;
            MODE_INT2: prod_sel = p2;
            default:   prod_sel = '0;
        endcase
    end

    // NOTE: all state below is sequential and uses non-blocking assignments,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state     <= ST_EMPTY;
            pack_mode <= MODE_INT8;
            pa        <= '0;
            pb        <= '0;
            mask      <= '0;
            lane_idx  <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_mode  <= '0;
            out_lanes <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        if (req_mode == MODE_RSVD) begin
                            // Consumed and dropped; the pack stays empty.
                            err <= 1'b1;
                        end else begin
                            pa        <= pa_ins;
                            pb        <= pb_ins;
                            mask      <= mask_ins;
                            pack_mode <= req_mode;
                            lane_idx  <= lane_idx + 2'd1;
                            cnt       <= '0;
                            state     <= (full_ins || flush) ? ST_ISSUE : ST_FILL;
                        end
                    end
                end

                ST_FILL: begin
                    if (mismatch) begin
                        state <= ST_ISSUE;
                    end else if (in_valid) begin
                        pa       <= pa_ins;
                        pb       <= pb_ins;
                        mask     <= mask_ins;
                        lane_idx <= lane_idx + 2'd1;
                        cnt      <= '0;
                        state    <= (full_ins || flush) ? ST_ISSUE : ST_FILL;
                    end else if (flush || timeout_hit) begin
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_ISSUE: begin
                    out_data  <= prod_sel;
                    out_lanes <= mask;
                    out_mode  <= pack_mode;
                    out_valid <= 1'b1;
                    pa        <= '0;
                    pb        <= '0;
                    mask      <= '0;
                    lane_idx  <= '0;
                    cnt       <= '0;
                    state     <= ST_OUT;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end

                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_mul_scheduler.sv
// tb_simd_mul_scheduler
//   Directed bench for simd_mul_scheduler with TIMEOUT = 4. Expected values
//   are hand-computed products, masks and cycle counts.
module tb_simd_mul_scheduler;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_mode;
    logic [3:0]  out_lanes;
    logic [15:0] out_data;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    simd_mul_scheduler #(.TIMEOUT(4)) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_lanes (out_lanes),
        .out_data  (out_data),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                         input logic fl);
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
        flush    = fl;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_mode  = 2'b00;
        in_a     = 8'h00;
        in_b     = 8'h00;
        flush    = 1'b0;
    endtask

    // Present one request for a single edge (in_ready is expected high).
    task automatic send(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b,
                        input logic fl);
        drive(mode, a, b, fl);
        tick();
        idle();
    endtask

    // Wait (bounded) for a result, compare it and consume it.
    task automatic collect(input string tag, input logic [15:0] d, input logic [3:0] l,
                           input logic [1:0] m);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_data"},  32'(out_data),  32'(d));
        check({tag, " out_lanes"}, 32'(out_lanes), 32'(l));
        check({tag, " out_mode"},  32'(out_mode),  32'(m));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst      = 1'b0;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst err",       32'(err),       32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        check("rst out_lanes", 32'(out_lanes), 32'd0);
        check("rst out_mode",  32'(out_mode),  32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        nrst = 1'b1;
        tick();

        // int8 with exact latency: accept edge, ISSUE, then valid.
        drive(2'b00, 8'hFF, 8'hFF, 1'b0);
        #1;
        check("int8 in_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
        check("int8 issue no valid", 32'(out_valid), 32'd0);
        check("int8 issue in_ready", 32'(in_ready),  32'd0);
        tick();
        check("int8 latency valid", 32'(out_valid), 32'd1);
        collect("int8", 16'hFE01, 4'b0001, 2'b00);
        check("int8 back to empty", 32'(in_ready), 32'd1);

        // int4 two lanes: 15*15 = 0xE1, 10*3 = 0x1E.
        send(2'b01, 8'h0F, 8'h0F, 1'b0);
        send(2'b01, 8'h0A, 8'h03, 1'b0);
        collect("int4", 16'h1EE1, 4'b0011, 2'b01);

        // int2 four lanes: 9, 2, 1, 0 with upper operand bits ignored.
        send(2'b10, 8'hF3, 8'h03, 1'b0);
        send(2'b10, 8'h02, 8'hFD, 1'b0);
        send(2'b10, 8'h01, 8'h01, 1'b0);
        send(2'b10, 8'h00, 8'h03, 1'b0);
        collect("int2", 16'h0129, 4'b1111, 2'b10);

        // Timeout: accept at edge k, ISSUE after edge k+4, valid after k+5.
        send(2'b10, 8'h03, 8'h02, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("tmo wait%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        tick();
        check("tmo issue in_ready", 32'(in_ready),  32'd0);
        check("tmo issue no valid", 32'(out_valid), 32'd0);
        tick();
        check("tmo valid", 32'(out_valid), 32'd1);
        collect("tmo", 16'h0006, 4'b0001, 2'b10);

        // Flush with accept: issues on the next edge.
        send(2'b10, 8'h03, 8'h02, 1'b1);
        check("flush issue in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush valid", 32'(out_valid), 32'd1);
        collect("flush", 16'h0006, 4'b0001, 2'b10);

        // Flush alone in EMPTY does nothing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush empty no valid", 32'(out_valid), 32'd0);
        check("flush empty in_ready", 32'(in_ready),  32'd1);

        // Mode change: int8 request is refused until the int4 pack drains.
        send(2'b01, 8'h05, 8'h05, 1'b0);
        drive(2'b00, 8'hA0, 8'hFF, 1'b0);
        #1;
        check("mismatch in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("mismatch out_valid", 32'(out_valid), 32'd1);
        check("mismatch data",  32'(out_data),  32'h0019);
        check("mismatch lanes", 32'(out_lanes), 32'h1);
        check("mismatch mode",  32'(out_mode),  32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mismatch retry in_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
        collect("int8 after mismatch", 16'h9F60, 4'b0001, 2'b00);

        // Backpressure: 0x12 * 0x34 = 0x03A8 held while out_ready is low.
        send(2'b00, 8'h12, 8'h34, 1'b0);
        tick();
        drive(2'b00, 8'h55, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d valid", i),    32'(out_valid), 32'd1);
            check($sformatf("bp%0d data", i),     32'(out_data),  32'h03A8);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready),  32'd0);
            tick();
        end
        idle();
        collect("bp", 16'h03A8, 4'b0001, 2'b00);

        // Reserved mode in EMPTY: err pulse, request dropped.
        send(2'b11, 8'h07, 8'h07, 1'b0);
        check("rsvd err", 32'(err), 32'd1);
        check("rsvd in_ready", 32'(in_ready), 32'd1);
        tick();
        check("rsvd err drop", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rsvd%0d no valid", i), 32'(out_valid), 32'd0);
        end

        // Reset mid-FILL discards the pack; the next pack restarts at lane 0.
        send(2'b01, 8'h07, 8'h07, 1'b0);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("midrst%0d no valid", i), 32'(out_valid), 32'd0);
        end
        send(2'b01, 8'h02, 8'h03, 1'b1);
        collect("midrst next", 16'h0006, 4'b0001, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
